sdram_aref: RTL

- Periodic auto-refresh generator for the SDRAM controller. It sits directly downstream of the SDRAM power-up initialisation stage.
- Stays idle until initialisation completes (init_end). It then times the refresh interval and raises a refresh request to the controller arbiter.
- On grant, it issues one PRECHARGE-ALL followed by AREF_NUM AUTO REFRESH commands, respecting tRP and tRFC.
- Its command/bank/address outputs are muxed by the arbiter onto the SDRAM pins.

---
 rtl/sdram_aref.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sdram_aref.sv
// Periodic SDRAM auto-refresh generator: interval timer, request/grant handshake,
// and a PRECHARGE-ALL + AREF_NUM x AUTO REFRESH burst. Optional macro: SDRAM_AREF_OVERRUN_EN.
module sdram_aref #(
    parameter int CNT_REF_MAX = 749,
    parameter int TRP_CLK     = 2,
    parameter int TRFC_CLK    = 7,
    parameter int AREF_NUM    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_ba,
    output logic [12:0] aref_addr,
`ifdef SDRAM_AREF_OVERRUN_EN
    output logic        aref_overrun,
`endif
    output logic        aref_end
);

    localparam int REF_W_RAW = $clog2(CNT_REF_MAX + 1);
    localparam int REF_W     = (REF_W_RAW > 10) ? REF_W_RAW : 10;

    localparam logic [REF_W-1:0] REF_MAX_V = REF_W'(CNT_REF_MAX);
    localparam logic [3:0]       TRP_LAST  = 4'(TRP_CLK - 1);
    localparam logic [3:0]       TRFC_LAST = 4'(TRFC_CLK - 1);
    localparam logic [2:0]       AR_TOTAL  = 3'(AREF_NUM);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_TRP  = 3'd2,
        ST_AR   = 3'd3,
        ST_TRFC = 3'd4,
        ST_END  = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [REF_W-1:0]   cnt_ref_r;
    logic [3:0]         cnt_clk_r;
    logic [2:0]         cnt_ar_r;
    logic               aref_req_r;
    logic [3:0]         aref_cmd_r;
    logic               aref_end_r;
    logic               expire_s;
    logic               grant_s;

    assign expire_s = init_end && (cnt_ref_r == REF_MAX_V);
    assign grant_s  = (state_r == ST_IDLE) && aref_en;

    // Next-state decode of the refresh burst sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (aref_req_r && aref_en) begin
                    state_nxt_s = ST_PRE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRE:  state_nxt_s = ST_TRP;
            ST_TRP: begin
                if (cnt_clk_r == TRP_LAST) begin
                    state_nxt_s = ST_AR;
                end else begin
                    state_nxt_s = ST_TRP;
                end
            end
            ST_AR:   state_nxt_s = ST_TRFC;
            ST_TRFC: begin
                // cnt_ar_r already counts the AR just issued
                if (cnt_clk_r != TRFC_LAST) begin
                    state_nxt_s = ST_TRFC;
                end else if (cnt_ar_r < AR_TOTAL) begin
                    state_nxt_s = ST_AR;
                end else begin
                    state_nxt_s = ST_END;
                end
            end
            ST_END:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state, counters, request flag and outputs registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_ref_r  <= '0;
            cnt_clk_r  <= 4'd0;
            cnt_ar_r   <= 3'd0;
            aref_req_r <= 1'b0;
            aref_cmd_r <= CMD_NOP;
            aref_end_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;

            if ((state_nxt_s == state_r) && ((state_r == ST_TRP) || (state_r == ST_TRFC))) begin
                cnt_clk_r <= cnt_clk_r + 4'd1;
            end else begin
                cnt_clk_r <= 4'd0;
            end

            if (state_r == ST_AR) begin
                cnt_ar_r <= cnt_ar_r + 3'd1;
            end else if (state_r == ST_END) begin
                cnt_ar_r <= 3'd0;
            end else begin
                cnt_ar_r <= cnt_ar_r;
            end

            if (!init_end) begin
                cnt_ref_r <= '0;
            end else if (expire_s) begin
                cnt_ref_r <= '0;
            end else begin
                cnt_ref_r <= cnt_ref_r + REF_W'(1);
            end

            // A grant wins over a coincident expiry: requests never queue
            if (!init_end) begin
                aref_req_r <= 1'b0;
            end else if (grant_s) begin
                aref_req_r <= 1'b0;
            end else if (expire_s) begin
                aref_req_r <= 1'b1;
            end else begin
                aref_req_r <= aref_req_r;
            end

            case (state_nxt_s)
                ST_PRE:  aref_cmd_r <= CMD_PRE;
                ST_AR:   aref_cmd_r <= CMD_AR;
                default: aref_cmd_r <= CMD_NOP;
            endcase

            aref_end_r <= (state_nxt_s == ST_END);
        end
    end

`ifdef SDRAM_AREF_OVERRUN_EN
    logic aref_overrun_r;

    // Sticky flag: an interval expired while the previous request was still pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            aref_overrun_r <= 1'b0;
        end else if (expire_s && aref_req_r) begin
            aref_overrun_r <= 1'b1;
        end else begin
            aref_overrun_r <= aref_overrun_r;
        end
    end

    assign aref_overrun = aref_overrun_r;
`endif

    assign aref_req  = aref_req_r;
    assign aref_cmd  = aref_cmd_r;
    assign aref_end  = aref_end_r;
    assign aref_ba   = 2'b11;
    assign aref_addr = 13'h1FFF;

endmodule
